// File: rtl/pc_gen_bp_pkg.sv
// pc_gen_bp_pkg: shared counter encodings, BTB geometry helpers and counter update.
package pc_gen_bp_pkg;

    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_e;

    function automatic int btb_idx_w(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int btb_tag_w(input int addr_w, input int depth);
        return addr_w - $clog2(depth) - 2;
    endfunction

    function automatic ctr_e ctr_step(input ctr_e c, input logic taken);
        return taken ? ((c == CTR_ST)  ? CTR_ST  : ctr_e'(c + 2'd1))
                     : ((c == CTR_SNT) ? CTR_SNT : ctr_e'(c - 2'd1));
    endfunction

endpackage

// File: rtl/pc_gen_bp_btb.sv
// pc_btb: direct-mapped branch target buffer with 2-bit saturating direction counters.
module pc_btb
    import pc_gen_bp_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int BTB_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_rdy,
    input  logic [ADDR_W-1:0] i_pc,
    input  logic [ADDR_W-1:0] i_npc,
    output logic              o_pred_taken,
    output logic [ADDR_W-1:0] o_pred_target,
    input  logic              i_upd_e,
    input  logic [ADDR_W-1:0] i_upd_pc,
    input  logic              i_upd_taken,
    input  logic [ADDR_W-1:0] i_upd_target
);
    localparam int IDX_W = btb_idx_w(BTB_DEPTH);
    localparam int TAG_W = btb_tag_w(ADDR_W, BTB_DEPTH);

    logic              r_valid [BTB_DEPTH];
    ctr_e              r_ctr   [BTB_DEPTH];
    logic [TAG_W-1:0]  r_tag   [BTB_DEPTH];
    logic [ADDR_W-3:0] r_tgt   [BTB_DEPTH];

    logic [IDX_W-1:0] w_idx, w_uidx;
    logic [TAG_W-1:0] w_tag, w_utag;
    logic             w_hit, w_uhit;
    ctr_e             w_ctr;
    logic             w_unused;

    assign w_idx   = i_pc[IDX_W+1:2];
    assign w_tag   = i_pc[ADDR_W-1:IDX_W+2];
    assign w_uidx  = i_upd_pc[IDX_W+1:2];
    assign w_utag  = i_upd_pc[ADDR_W-1:IDX_W+2];
    assign w_hit   = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_uhit  = r_valid[w_uidx] && (r_tag[w_uidx] == w_utag);
    assign w_ctr   = r_ctr[w_idx];
    assign w_unused = ^{i_pc[1:0], i_upd_pc[1:0], i_upd_target[1:0]};

    assign o_pred_taken  = w_hit && w_ctr[1];
    assign o_pred_target = w_hit ? {r_tgt[w_idx], 2'b00} : i_npc;

    // Lookup is purely combinational on the current entries, so same-cycle updates are seen next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BTB_DEPTH; i++) begin
                r_valid[i] <= 1'b0;
                r_ctr[i]   <= CTR_WNT;
            end
        end else if (i_rdy && i_upd_e) begin
            if (i_upd_taken) begin
                r_valid[w_uidx] <= 1'b1;
                r_tag[w_uidx]   <= w_utag;
                r_tgt[w_uidx]   <= i_upd_target[ADDR_W-1:2];
            end
            if (i_upd_taken || w_uhit)
                r_ctr[w_uidx] <= w_uhit ? ctr_step(r_ctr[w_uidx], i_upd_taken) : CTR_WT;
        end
    end

endmodule

// File: rtl/pc_gen_bp.sv
// pc_gen_bp: fetch PC generator with held redirects and BTB-driven prediction.
module pc_gen_bp
    import pc_gen_bp_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter int                BTB_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              stall,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] npc,
    output logic              pc_e,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_target,
    input  logic              jmp_e,
    input  logic [ADDR_W-1:0] jmp_target,
    input  logic              upd_e,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic              upd_taken,
    input  logic [ADDR_W-1:0] upd_target
);
    logic [ADDR_W-1:0] r_pc, r_npc, r_pend_tgt;
    logic              r_pc_e, r_pend_v;
    logic [ADDR_W-1:0] w_jmp_tgt, w_next_pc;
    logic              w_unused;

    assign w_jmp_tgt = {jmp_target[ADDR_W-1:2], 2'b00};
    assign w_unused  = ^jmp_target[1:0];
    assign w_next_pc = jmp_e ? w_jmp_tgt : r_pend_v ? r_pend_tgt : pred_taken ? pred_target : r_npc;

    assign pc   = r_pc;
    assign npc  = r_npc;
    assign pc_e = r_pc_e;

    pc_btb #(.ADDR_W(ADDR_W), .BTB_DEPTH(BTB_DEPTH)) u_btb (
        .clk          (clk),
        .rst          (rst),
        .i_rdy        (rdy),
        .i_pc         (r_pc),
        .i_npc        (r_npc),
        .o_pred_taken (pred_taken),
        .o_pred_target(pred_target),
        .i_upd_e      (upd_e),
        .i_upd_pc     (upd_pc),
        .i_upd_taken  (upd_taken),
        .i_upd_target (upd_target)
    );

    // A redirect seen during a stall is parked; the newest one wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_npc      <= RESET_PC + ADDR_W'(4);
            r_pc_e     <= 1'b1;
            r_pend_v   <= 1'b0;
            r_pend_tgt <= '0;
        end else if (rdy) begin
            if (!stall) begin
                r_pc     <= w_next_pc;
                r_npc    <= w_next_pc + ADDR_W'(4);
                r_pc_e   <= 1'b1;
                r_pend_v <= 1'b0;
            end else begin
                r_pc_e <= 1'b0;
                if (jmp_e) begin
                    r_pend_v   <= 1'b1;
                    r_pend_tgt <= w_jmp_tgt;
                end
            end
        end
    end

endmodule

// File: tb/tb_pc_gen_bp.sv
// tb_pc_gen_bp: directed stimulus checked every cycle against an address-level fetch/BTB model.
module tb_pc_gen_bp;
    logic        clk = 1'b0;
    logic        rst = 1'b1, rdy = 1'b1, stall = 1'b0;
    logic [31:0] pc, npc, pred_target;
    logic        pc_e, pred_taken;
    logic        jmp_e = 1'b0, upd_e = 1'b0, upd_taken = 1'b0;
    logic [31:0] jmp_target = '0, upd_pc = '0, upd_target = '0;

    int n_chk = 0, n_fail = 0;

    logic [31:0] m_pc, m_pend_t;
    bit          m_pc_e, m_pend_v;
    bit          mv   [16];
    logic [31:0] mbpc [16];
    logic [31:0] mtgt [16];
    int          mctr [16];

    always #5 clk = ~clk;

    pc_gen_bp dut (
        .clk(clk), .rst(rst), .rdy(rdy), .stall(stall),
        .pc(pc), .npc(npc), .pc_e(pc_e),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .jmp_e(jmp_e), .jmp_target(jmp_target),
        .upd_e(upd_e), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target)
    );

    function automatic int slot(input logic [31:0] a);
        return int'((a >> 2) % 16);
    endfunction

    function automatic bit m_hit(input logic [31:0] a);
        return mv[slot(a)] && (mbpc[slot(a)][31:2] == a[31:2]);
    endfunction

    function automatic bit m_ptk(input logic [31:0] a);
        return m_hit(a) && (mctr[slot(a)] >= 2);
    endfunction

    function automatic logic [31:0] m_ptg(input logic [31:0] a);
        return m_hit(a) ? mtgt[slot(a)] : a + 32'd4;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        int  u;
        bit  h;
        if (rst) begin
            m_pc = 32'h0; m_pc_e = 1; m_pend_v = 0; m_pend_t = 32'h0;
            for (int i = 0; i < 16; i++) begin mv[i] = 0; mctr[i] = 1; end
        end else if (rdy) begin
            if (!stall) begin
                m_pc = jmp_e ? (jmp_target & ~32'd3) : m_pend_v ? m_pend_t
                     : m_ptk(m_pc) ? m_ptg(m_pc) : m_pc + 32'd4;
                m_pc_e = 1; m_pend_v = 0;
            end else begin
                m_pc_e = 0;
                if (jmp_e) begin m_pend_v = 1; m_pend_t = jmp_target & ~32'd3; end
            end
            if (upd_e) begin
                u = slot(upd_pc);
                h = m_hit(upd_pc);
                if (upd_taken) begin
                    mv[u] = 1; mbpc[u] = upd_pc; mtgt[u] = upd_target & ~32'd3;
                    mctr[u] = h ? (mctr[u] == 3 ? 3 : mctr[u] + 1) : 2;
                end else if (h) begin
                    mctr[u] = mctr[u] == 0 ? 0 : mctr[u] - 1;
                end
            end
        end
        @(posedge clk);
        #1;
        chk("pc", pc, m_pc);
        chk("npc", npc, m_pc + 32'd4);
        chk("pc_e", 32'(pc_e), 32'(m_pc_e));
        chk("pred_taken", 32'(pred_taken), 32'(m_ptk(m_pc)));
        chk("pred_target", pred_target, m_ptg(m_pc));
    endtask

    task automatic jump(input logic [31:0] t);
        jmp_e = 1; jmp_target = t; step(); jmp_e = 0;
    endtask

    task automatic train(input logic [31:0] a, input logic tk, input logic [31:0] t, input int n);
        upd_e = 1; upd_pc = a; upd_taken = tk; upd_target = t;
        for (int i = 0; i < n; i++) step();
        upd_e = 0;
    endtask

    initial begin
        step(); step();
        chk("lit_reset_pc", pc, 32'h0);
        chk("lit_reset_pc_e", 32'(pc_e), 32'd1);
        chk("lit_reset_ptk", 32'(pred_taken), 32'd0);
        rst = 0;
        for (int i = 0; i < 4; i++) step();
        chk("lit_seq_pc", pc, 32'h10);

        stall = 1; jump(32'h200); step(); step();
        chk("lit_stall_pc", pc, 32'h10);
        chk("lit_stall_pc_e", 32'(pc_e), 32'd0);
        stall = 0; step();
        chk("lit_pend_pc", pc, 32'h200);
        chk("lit_pend_npc", npc, 32'h204);

        stall = 1; jump(32'h300); jump(32'h400); stall = 0; step();
        chk("lit_newest_pend", pc, 32'h400);

        train(32'h40, 1, 32'h80, 2);
        jump(32'h38); step(); step();
        chk("lit_btb_ptk", 32'(pred_taken), 32'd1);
        chk("lit_btb_ptg", pred_target, 32'h80);
        step();
        chk("lit_btb_pc", pc, 32'h80);

        train(32'h40, 0, 32'h0, 2);
        jump(32'h40);
        chk("lit_nt_ptk", 32'(pred_taken), 32'd0);
        step();
        chk("lit_nt_pc", pc, 32'h44);

        train(32'h40, 1, 32'h80, 2);
        jump(32'h40);
        chk("lit_rt_ptk", 32'(pred_taken), 32'd1);
        jump(32'h500);
        chk("lit_jmp_wins", pc, 32'h500);

        rdy = 0; jmp_e = 1; jmp_target = 32'h600;
        upd_e = 1; upd_pc = 32'h500; upd_taken = 1; upd_target = 32'h700;
        step(); step(); step();
        chk("lit_frz_pc", pc, 32'h500);
        chk("lit_frz_ptk", 32'(pred_taken), 32'd0);
        rdy = 1; jmp_e = 0; upd_e = 0; step();
        chk("lit_resume_pc", pc, 32'h504);

        jump(32'h84);
        train(32'h84, 1, 32'hA00, 1);
        chk("lit_rbw_pc", pc, 32'h88);
        jump(32'h84); step();
        chk("lit_wt_pc", pc, 32'hA00);

        jump(32'hFFFF_FFFC);
        chk("lit_wrap_npc", npc, 32'h0);
        step();
        chk("lit_wrap_pc", pc, 32'h0);

        stall = 1; jump(32'h900); rst = 1; step(); rst = 0; stall = 0; step();
        chk("lit_rst_drop", pc, 32'h4);

        for (int i = 0; i < 6; i++) begin stall = i[0]; step(); end
        stall = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
